// File: rtl/chu_gpi_sampler_pkg.sv
// rtl/chu_gpi_sampler_pkg.sv - register map, ctrl/status bit indices and FSM states for the GPI sampler
package chu_gpi_sampler_pkg;

    localparam int TS_W = 16;

    localparam logic [2:0] REG_LIVE     = 3'd0;
    localparam logic [2:0] REG_HEAD     = 3'd1;
    localparam logic [2:0] REG_POP      = 3'd2;
    localparam logic [2:0] REG_CTRL     = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;
    localparam logic [2:0] REG_STATUS   = 3'd5;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_CLR    = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/chu_gpi_sampler_if.sv
// rtl/chu_gpi_sampler_if.sv - MMIO slot bus between the processor side and the sampler core
interface chu_gpi_sampler_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/gpi_sample_fifo.sv
// rtl/gpi_sample_fifo.sv - register-array sample FIFO with clear, occupancy count and full/empty flags
module gpi_sample_fifo #(
    parameter int DATA_W     = 24,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty = (count == '0);
    assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign head  = mem[rd_ptr];

    // A push into a full FIFO only lands when a pop frees the slot in the same cycle
    assign do_push = push & ~clr & (~full | pop);
    assign do_pop  = pop & ~clr & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/chu_gpi_sampler.sv
// rtl/chu_gpi_sampler.sv - MMIO core that samples, timestamps and buffers a GPI port under hardware control
module chu_gpi_sampler
    import chu_gpi_sampler_pkg::*;
#(
    parameter int W          = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    chu_gpi_sampler_if.slave      slot,
    input  logic [W-1:0]          din,
    output logic                  irq
);
    logic [W-1:0]          sync_q;
    logic [W-1:0]          sdin;
    state_t                state;
    state_t                state_next;
    logic                  mode;
    logic                  irq_en;
    logic [15:0]           prescale;
    logic [15:0]           cnt;
    logic [TS_W-1:0]       ts;
    logic [W-1:0]          last;
    logic                  first;
    logic                  overflow;

    logic                  wr_en;
    logic                  wr_ctrl;
    logic                  wr_prescale;
    logic                  wr_status;
    logic                  pop;
    logic                  clr;
    logic                  enter_run;
    logic                  run;
    logic                  tick;
    logic                  push_req;

    logic [TS_W+W-1:0]     fifo_head;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  unused_bits;

    assign wr_en       = slot.cs & slot.write;
    assign wr_ctrl     = wr_en & (slot.addr[2:0] == REG_CTRL);
    assign wr_prescale = wr_en & (slot.addr[2:0] == REG_PRESCALE);
    assign wr_status   = wr_en & (slot.addr[2:0] == REG_STATUS);
    assign pop         = wr_en & (slot.addr[2:0] == REG_POP);
    assign clr         = wr_ctrl & slot.wr_data[CTRL_CLR];

    assign unused_bits = ^{slot.read, slot.addr[4:3], slot.wr_data[31:16]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            sdin   <= '0;
        end else begin
            sync_q <= din;
            sdin   <= sync_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (wr_ctrl && slot.wr_data[CTRL_EN])  state_next = RUN;
            RUN:  if (wr_ctrl && !slot.wr_data[CTRL_EN]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_run = (state == IDLE) && (state_next == RUN);
    assign run       = (state == RUN);
    // A tick coinciding with clr is discarded entirely (no push, no timestamp advance)
    assign tick      = run & (cnt == prescale) & ~clr;
    assign push_req  = tick & (~mode | first | (sdin != last));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode     <= 1'b0;
            irq_en   <= 1'b0;
            prescale <= '0;
            cnt      <= '0;
            ts       <= '0;
            last     <= '0;
            first    <= 1'b1;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                mode   <= slot.wr_data[CTRL_MODE];
                irq_en <= slot.wr_data[CTRL_IRQ_EN];
            end
            if (wr_prescale)
                prescale <= slot.wr_data[15:0];

            // cnt above a freshly lowered N wraps to 0 without producing a tick
            if (enter_run)
                cnt <= '0;
            else if (run)
                cnt <= (cnt >= prescale) ? 16'd0 : cnt + 16'd1;

            if (tick)
                ts <= ts + 1'b1;

            if (push_req)
                last <= sdin;
            if (clr || enter_run)
                first <= 1'b1;
            else if (push_req)
                first <= 1'b0;

            if (clr || (wr_status && slot.wr_data[STAT_OVF]))
                overflow <= 1'b0;
            else if (push_req && fifo_full && !pop)
                overflow <= 1'b1;

            irq <= irq_en & (~fifo_empty | overflow);
        end
    end

    gpi_sample_fifo #(
        .DATA_W     (TS_W + W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .clr   (clr),
        .wdata ({ts, sdin}),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        slot.rd_data = '0;
        case (slot.addr[2:0])
            REG_LIVE: slot.rd_data[W-1:0] = sdin;
            REG_HEAD: begin
                if (!fifo_empty) begin
                    slot.rd_data[W-1:0]   = fifo_head[W-1:0];
                    slot.rd_data[31:16]   = fifo_head[TS_W+W-1:W];
                end
            end
            REG_CTRL: begin
                slot.rd_data[CTRL_EN]     = run;
                slot.rd_data[CTRL_MODE]   = mode;
                slot.rd_data[CTRL_IRQ_EN] = irq_en;
            end
            REG_PRESCALE: slot.rd_data[15:0] = prescale;
            REG_STATUS: begin
                slot.rd_data[STAT_EMPTY] = fifo_empty;
                slot.rd_data[STAT_FULL]  = fifo_full;
                slot.rd_data[STAT_OVF]   = overflow;
                slot.rd_data[STAT_COUNT_LSB +: DEPTH_LOG2+1] = fifo_count;
            end
            default: slot.rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_chu_gpi_sampler.sv
// tb/tb_chu_gpi_sampler.sv - directed self-checking bench for chu_gpi_sampler
module tb_chu_gpi_sampler;
    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       irq;
    int         checks;
    int         errors;

    chu_gpi_sampler_if bus ();

    chu_gpi_sampler #(.W(8), .DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .reset (reset),
        .slot  (bus),
        .din   (din),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.cs      = 1'b1;
        bus.write   = 1'b1;
        bus.addr    = {2'b00, a};
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.cs      = 1'b0;
        bus.write   = 1'b0;
        bus.wr_data = '0;
    endtask

    task automatic chk_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus.addr = {2'b00, a};
        bus.read = 1'b1;
        #1;
        d = bus.rd_data;
        bus.read = 1'b0;
        check(tag, d, exp);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        din         = 8'h00;
        bus.cs      = 1'b0;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.addr    = '0;
        bus.wr_data = '0;
        cycles(3);
        chk_rd("rst_status", 3'd5, 32'h1);
        chk_rd("rst_ctrl", 3'd3, 32'h0);
        chk_rd("rst_head", 3'd1, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        reset = 1'b0;

        // periodic sampling, N=3
        din = 8'h5A;
        cycles(3);
        chk_rd("live", 3'd0, 32'h5A);
        wr(3'd4, 32'd3);
        chk_rd("prescale_rb", 3'd4, 32'd3);
        wr(3'd3, 32'h1);
        chk_rd("ctrl_rb", 3'd3, 32'h1);
        cycles(4);
        chk_rd("per_status1", 3'd5, 32'h100);
        chk_rd("per_head1", 3'd1, 32'h0000_005A);
        check("per_irq_off", {31'd0, irq}, 32'h0);
        cycles(4);
        chk_rd("per_status2", 3'd5, 32'h200);
        chk_rd("per_head_nd", 3'd1, 32'h0000_005A);
        wr(3'd2, 32'h0);
        chk_rd("per_head_pop", 3'd1, 32'h0001_005A);
        chk_rd("per_status_pop", 3'd5, 32'h100);
        wr(3'd3, 32'h0);
        wr(3'd3, 32'h4);
        chk_rd("per_clr", 3'd5, 32'h1);
        chk_rd("clr_reads0", 3'd3, 32'h0);

        // on-change mode, N=0, ts continues from 2
        din = 8'h01;
        cycles(3);
        wr(3'd4, 32'd0);
        wr(3'd3, 32'h3);
        cycles(10);
        din = 8'h02;
        cycles(5);
        chk_rd("chg_status", 3'd5, 32'h200);
        chk_rd("chg_head1", 3'd1, 32'h0002_0001);
        wr(3'd2, 32'h0);
        chk_rd("chg_head2", 3'd1, 32'h000E_0002);
        chk_rd("chg_status2", 3'd5, 32'h100);
        wr(3'd3, 32'h0);
        wr(3'd3, 32'h4);

        // overflow after a fresh reset
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(3);
        wr(3'd4, 32'd0);
        wr(3'd3, 32'h9);
        cycles(17);
        wr(3'd3, 32'h8);
        chk_rd("ovf_status", 3'd5, 32'h1006);
        check("ovf_irq", {31'd0, irq}, 32'h1);
        chk_rd("ovf_head", 3'd1, 32'h0000_0002);
        wr(3'd5, 32'h4);
        chk_rd("ovf_cleared", 3'd5, 32'h1002);
        check("ovf_irq_hold", {31'd0, irq}, 32'h1);

        // full with simultaneous push and pop, N=1
        wr(3'd4, 32'd1);
        wr(3'd3, 32'h9);
        cycles(1);
        wr(3'd2, 32'h0);
        wr(3'd3, 32'h8);
        chk_rd("pp_status", 3'd5, 32'h1002);
        chk_rd("pp_head", 3'd1, 32'h0001_0002);

        // clr, empty pop, clr with 5 entries
        wr(3'd3, 32'hC);
        chk_rd("clr_status", 3'd5, 32'h1);
        cycles(1);
        check("clr_irq", {31'd0, irq}, 32'h0);
        wr(3'd2, 32'h0);
        chk_rd("epop_status", 3'd5, 32'h1);
        chk_rd("epop_head", 3'd1, 32'h0);
        wr(3'd4, 32'd0);
        wr(3'd3, 32'h9);
        cycles(4);
        wr(3'd3, 32'h8);
        chk_rd("five_status", 3'd5, 32'h500);
        chk_rd("five_head", 3'd1, 32'h0013_0002);
        check("five_irq", {31'd0, irq}, 32'h1);
        wr(3'd3, 32'hC);
        chk_rd("five_clr", 3'd5, 32'h1);
        cycles(1);
        check("five_clr_irq", {31'd0, irq}, 32'h0);

        // async reset mid-RUN with 7 entries
        wr(3'd3, 32'h9);
        chk_rd("run_ctrl", 3'd3, 32'h9);
        cycles(6);
        wr(3'd4, 32'h1234);
        chk_rd("seven_status", 3'd5, 32'h700);
        chk_rd("seven_prescale", 3'd4, 32'h1234);
        #3;
        reset = 1'b1;
        #1;
        chk_rd("ar_status", 3'd5, 32'h1);
        chk_rd("ar_ctrl", 3'd3, 32'h0);
        chk_rd("ar_prescale", 3'd4, 32'h0);
        chk_rd("ar_head", 3'd1, 32'h0);
        chk_rd("ar_live", 3'd0, 32'h0);
        check("ar_irq", {31'd0, irq}, 32'h0);
        cycles(1);
        reset = 1'b0;
        wr(3'd6, 32'hFFFF_FFFF);
        chk_rd("unmapped6", 3'd6, 32'h0);
        chk_rd("unmapped7", 3'd7, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
